// File: rtl/deskew_pkg.sv
// Shared encodings and defaults for the lane deskew supervisor.
// Revision 1.0
`default_nettype none

package deskew_pkg;

  localparam int c_DEFAULT_N_LANES = 20;
  localparam int c_RELOCK_W        = 8;

  localparam logic [4:0] c_ST_WAIT_LOCK   = 5'b00001;
  localparam logic [4:0] c_ST_RESYNC      = 5'b00010;
  localparam logic [4:0] c_ST_WAIT_DESKEW = 5'b00100;
  localparam logic [4:0] c_ST_ALIGNED     = 5'b01000;
  localparam logic [4:0] c_ST_FAIL        = 5'b10000;

  typedef enum logic [4:0] {
    S_WAIT_LOCK   = c_ST_WAIT_LOCK,
    S_RESYNC      = c_ST_RESYNC,
    S_WAIT_DESKEW = c_ST_WAIT_DESKEW,
    S_ALIGNED     = c_ST_ALIGNED,
    S_FAIL        = c_ST_FAIL
  } state_t;

endpackage

`default_nettype wire

// File: rtl/deskew_supervisor_if.sv
// Control/status bundle between lock logic, deskew FSM, register file and the supervisor.
// Optional DESKEW_SUP_STATS_EN adds o_relock_count. Revision 1.0
`default_nettype none

interface deskew_supervisor_if
  import deskew_pkg::*;
#(
  parameter int N_LANES  = c_DEFAULT_N_LANES,
  parameter int NB_RETRY = 2
);
  logic               i_enable;
  logic [N_LANES-1:0] i_am_lock;
  logic               i_deskew_done;
  logic               i_invalid_skew;
  logic               i_restart;
  logic               o_resync;
  logic               o_deskew_enable;
  logic               o_aligned;
  logic               o_fail;
  logic [NB_RETRY-1:0] o_retry_count;
`ifdef DESKEW_SUP_STATS_EN
  logic [c_RELOCK_W-1:0] o_relock_count;
`endif

  modport master (
    output i_enable, i_am_lock, i_deskew_done, i_invalid_skew, i_restart,
`ifdef DESKEW_SUP_STATS_EN
    input  o_relock_count,
`endif
    input  o_resync, o_deskew_enable, o_aligned, o_fail, o_retry_count
  );

  modport slave (
    input  i_enable, i_am_lock, i_deskew_done, i_invalid_skew, i_restart,
`ifdef DESKEW_SUP_STATS_EN
    output o_relock_count,
`endif
    output o_resync, o_deskew_enable, o_aligned, o_fail, o_retry_count
  );

endinterface

`default_nettype wire

// File: rtl/deskew_timeout_counter.sv
// Clearable up-counter with a registered flag that is high while the count equals TERMINAL.
// Revision 1.0
`default_nettype none

module deskew_timeout_counter #(
  parameter int WIDTH    = 7,
  parameter int TERMINAL = 63
) (
  input  wire logic i_clock,
  input  wire logic i_reset,
  input  wire logic i_clear,
  input  wire logic i_enable,
  output logic      o_tc
);
  localparam logic [WIDTH-1:0] c_TERM = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_tc;

  always_comb begin
    w_count_nxt = r_count;
    if (i_clear)
      w_count_nxt = '0;
    else if (i_enable)
      w_count_nxt = r_count + WIDTH'(1);
  end

  // Flag is computed from the next count so it lines up with r_count exactly.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
      r_tc    <= (c_TERM == '0);
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= (w_count_nxt == c_TERM);
    end
  end

  assign o_tc = r_tc;

endmodule

`default_nettype wire

// File: rtl/deskew_supervisor.sv
// Sequences deskew attempts: waits for AM lock, pulses resync, supervises timeout/retries.
// Optional DESKEW_SUP_STATS_EN adds a saturating relock counter. Revision 1.0
`default_nettype none

module deskew_supervisor
  import deskew_pkg::*;
#(
  parameter int N_LANES    = c_DEFAULT_N_LANES,
  parameter int TIMEOUT    = 64,
  parameter int MAX_RETRY  = 3,
  parameter int NB_TIMEOUT = $clog2(TIMEOUT + 1),
  parameter int NB_RETRY   = $clog2(MAX_RETRY + 1)
) (
  input  wire logic            i_clock,
  input  wire logic            i_reset,
  deskew_supervisor_if.slave   io_sup
);
  localparam logic [NB_RETRY-1:0] c_RETRY_LAST = NB_RETRY'(MAX_RETRY - 1);
  localparam logic [NB_RETRY-1:0] c_RETRY_MAX  = NB_RETRY'(MAX_RETRY);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NB_RETRY-1:0] r_retry;
  logic [NB_RETRY-1:0] w_retry_nxt;
  logic                w_all_locked;
  logic                w_tc;
  logic                w_cnt_clear;
  logic                w_cnt_en;

  assign w_all_locked = &io_sup.i_am_lock;
  assign w_cnt_en     = io_sup.i_enable && (r_state == S_WAIT_DESKEW);
  assign w_cnt_clear  = io_sup.i_enable && (r_state != S_WAIT_DESKEW);

  deskew_timeout_counter #(
    .WIDTH    (NB_TIMEOUT),
    .TERMINAL (TIMEOUT - 1)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_cnt_clear),
    .i_enable (w_cnt_en),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    if (io_sup.i_restart) begin
      w_state_nxt = S_WAIT_LOCK;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          if (w_all_locked)
            w_state_nxt = S_RESYNC;
        end
        S_RESYNC: begin
          w_state_nxt = S_WAIT_DESKEW;
        end
        S_WAIT_DESKEW: begin
          if (!w_all_locked) begin
            w_state_nxt = S_WAIT_LOCK;
            w_retry_nxt = '0;
          end else if (io_sup.i_deskew_done) begin
            w_state_nxt = S_ALIGNED;
            w_retry_nxt = '0;
          end else if (io_sup.i_invalid_skew || w_tc) begin
            if (r_retry == c_RETRY_LAST) begin
              w_state_nxt = S_FAIL;
              w_retry_nxt = c_RETRY_MAX;
            end else begin
              w_state_nxt = S_RESYNC;
              w_retry_nxt = r_retry + NB_RETRY'(1);
            end
          end
        end
        S_ALIGNED: begin
          if (!w_all_locked)
            w_state_nxt = S_WAIT_LOCK;
        end
        S_FAIL: begin
          if (!w_all_locked) begin
            w_state_nxt = S_WAIT_LOCK;
            w_retry_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = S_WAIT_LOCK;
          w_retry_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_WAIT_LOCK;
      r_retry <= '0;
    end else if (io_sup.i_enable) begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
    end
  end

  assign io_sup.o_resync        = (r_state == S_RESYNC);
  assign io_sup.o_deskew_enable = (r_state == S_WAIT_DESKEW) || (r_state == S_ALIGNED);
  assign io_sup.o_aligned       = (r_state == S_ALIGNED);
  assign io_sup.o_fail          = (r_state == S_FAIL);
  assign io_sup.o_retry_count   = r_retry;

`ifdef DESKEW_SUP_STATS_EN
  logic [c_RELOCK_W-1:0] r_relock;

  // Counts every exit from ALIGNED, whether from lock loss or software restart.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_relock <= '0;
    else if (io_sup.i_enable && (r_state == S_ALIGNED) && (w_state_nxt == S_WAIT_LOCK)
             && (r_relock != '1))
      r_relock <= r_relock + c_RELOCK_W'(1);
  end

  assign io_sup.o_relock_count = r_relock;
`endif

endmodule

`default_nettype wire

// File: tb/tb_deskew_supervisor.sv
// Self-checking bench for deskew_supervisor: directed vector table, timing sequences, random vs model.
// Revision 1.0
`default_nettype none

module tb_deskew_supervisor;
  localparam int N_LANES    = 20;
  localparam int TIMEOUT    = 64;
  localparam int MAX_RETRY  = 3;
  localparam int NB_TIMEOUT = $clog2(TIMEOUT + 1);
  localparam int NB_RETRY   = $clog2(MAX_RETRY + 1);
  localparam logic [N_LANES-1:0] ALL    = '1;
  localparam logic [N_LANES-1:0] NO_L7  = ALL & ~(N_LANES'(1) << 7);
  localparam logic [N_LANES-1:0] NO_L3  = ALL & ~(N_LANES'(1) << 3);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deskew_supervisor_if #(.N_LANES(N_LANES), .NB_RETRY(NB_RETRY)) sup ();

  deskew_supervisor #(
    .N_LANES(N_LANES), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY),
    .NB_TIMEOUT(NB_TIMEOUT), .NB_RETRY(NB_RETRY)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_sup  (sup)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the supervisor's behaviour expressed as phases of an attempt.
  typedef enum int {P_IDLE, P_PULSE, P_ATTEMPT, P_LOCKED, P_GAVEUP} phase_t;
  phase_t m_phase  = P_IDLE;
  int     m_age    = 0;
  int     m_fails  = 0;
  int     m_relock = 0;

  task automatic model_step();
    bit all_ok;
    all_ok = (sup.i_am_lock == ALL);
    if (rst) begin
      m_phase = P_IDLE; m_age = 0; m_fails = 0; m_relock = 0;
    end else if (sup.i_enable) begin
      if (sup.i_restart) begin
        if (m_phase == P_LOCKED && m_relock < 255) m_relock++;
        m_phase = P_IDLE; m_fails = 0;
      end else begin
        case (m_phase)
          P_IDLE:  if (all_ok) m_phase = P_PULSE;
          P_PULSE: begin m_phase = P_ATTEMPT; m_age = 0; end
          P_ATTEMPT: begin
            if (!all_ok) begin m_phase = P_IDLE; m_fails = 0; end
            else if (sup.i_deskew_done) begin m_phase = P_LOCKED; m_fails = 0; end
            else if (sup.i_invalid_skew || m_age == TIMEOUT - 1) begin
              m_fails++;
              m_phase = (m_fails >= MAX_RETRY) ? P_GAVEUP : P_PULSE;
            end else m_age++;
          end
          P_LOCKED: if (!all_ok) begin
            m_phase = P_IDLE;
            if (m_relock < 255) m_relock++;
          end
          P_GAVEUP: if (!all_ok) begin m_phase = P_IDLE; m_fails = 0; end
          default: m_phase = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".resync"},  int'(sup.o_resync),        int'(m_phase == P_PULSE));
    check({tag, ".den"},     int'(sup.o_deskew_enable), int'(m_phase == P_ATTEMPT || m_phase == P_LOCKED));
    check({tag, ".aligned"}, int'(sup.o_aligned),       int'(m_phase == P_LOCKED));
    check({tag, ".fail"},    int'(sup.o_fail),          int'(m_phase == P_GAVEUP));
    check({tag, ".retry"},   int'(sup.o_retry_count),   m_fails);
`ifdef DESKEW_SUP_STATS_EN
    check({tag, ".relock"},  int'(sup.o_relock_count),  m_relock);
`endif
  endtask

  task automatic drive(input logic r, input logic en, input logic [N_LANES-1:0] lk,
                       input logic dn, input logic inv, input logic rs);
    rst = r; sup.i_enable = en; sup.i_am_lock = lk;
    sup.i_deskew_done = dn; sup.i_invalid_skew = inv; sup.i_restart = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic r, en; logic [N_LANES-1:0] lk; logic dn, inv, rs;
    logic e_res, e_den, e_al, e_fail; int e_retry;
  } vec_t;
  vec_t tbl[24];

  initial begin
    int rq[$];
    int n;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    //            r  en lock   dn inv rs  res den al fail retry
    tbl[0]  = '{1'b1,1'b1,'0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[1]  = '{1'b0,1'b1,'0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[2]  = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0};
    tbl[3]  = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 0};
    tbl[4]  = '{1'b0,1'b1,ALL,  1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0, 0};
    tbl[5]  = '{1'b0,1'b1,ALL,  1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0, 0};
    tbl[6]  = '{1'b0,1'b1,NO_L7,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[7]  = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0};
    tbl[8]  = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 0};
    tbl[9]  = '{1'b0,1'b1,ALL,  1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 1};
    tbl[10] = '{1'b0,1'b0,ALL,  1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 1};
    tbl[11] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 1};
    tbl[12] = '{1'b0,1'b1,ALL,  1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0, 2};
    tbl[13] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 2};
    tbl[14] = '{1'b0,1'b1,ALL,  1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1, 3};
    tbl[15] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1, 3};
    tbl[16] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[17] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0};
    tbl[18] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 0};
    tbl[19] = '{1'b0,1'b1,NO_L3,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[20] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0};
    tbl[21] = '{1'b1,1'b0,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[22] = '{1'b0,1'b0,ALL,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 0};
    tbl[23] = '{1'b0,1'b1,ALL,  1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 0};

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].r, tbl[i].en, tbl[i].lk, tbl[i].dn, tbl[i].inv, tbl[i].rs);
      tick();
      check($sformatf("vec%0d.resync", i),  int'(sup.o_resync),        int'(tbl[i].e_res));
      check($sformatf("vec%0d.den", i),     int'(sup.o_deskew_enable), int'(tbl[i].e_den));
      check($sformatf("vec%0d.aligned", i), int'(sup.o_aligned),       int'(tbl[i].e_al));
      check($sformatf("vec%0d.fail", i),    int'(sup.o_fail),          int'(tbl[i].e_fail));
      check($sformatf("vec%0d.retry", i),   int'(sup.o_retry_count),   tbl[i].e_retry);
    end
`ifdef DESKEW_SUP_STATS_EN
    check("vec.relock", int'(sup.o_relock_count), 1);
`endif

    // Locks rise at cycle 10, no done: three timed-out attempts then FAIL.
    do_reset();
    for (int c = 0; c < 216; c++) begin
      drive(1'b0, 1'b1, (c >= 10) ? ALL : '0, 1'b0, 1'b0, 1'b0);
      tick();
      check_model("tmo");
      if (sup.o_resync) rq.push_back(c + 1);
    end
    check("tmo.npulses", rq.size(), 3);
    if (rq.size() == 3) begin
      check("tmo.pulse0", rq[0], 11);
      check("tmo.pulse1", rq[1], 76);
      check("tmo.pulse2", rq[2], 141);
    end
    check("tmo.fail",  int'(sup.o_fail), 1);
    check("tmo.retry", int'(sup.o_retry_count), MAX_RETRY);

    // Timeout measured in enabled cycles, with a 10-cycle freeze mid-attempt.
    do_reset();
    drive(1'b0, 1'b1, ALL, 1'b0, 1'b0, 1'b0);
    tick(); check_model("frz.pre");
    tick(); check_model("frz.entry");
    n = 0;
    for (int k = 0; k < 200; k++) begin
      sup.i_enable = !(k >= 20 && k < 30);
      tick();
      check_model("frz");
      if (sup.i_enable) n++;
      if (sup.o_resync) break;
    end
    check("frz.len", n, TIMEOUT);

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      logic [N_LANES-1:0] lk;
      lk = ($urandom_range(0, 24) == 0) ? (ALL & ~(N_LANES'(1) << $urandom_range(0, N_LANES - 1))) : ALL;
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0, lk,
            $urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
      tick();
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
